// File: rtl/store_checker_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | store_checker_pkg : state and fail-code types for store_checker    |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
package store_checker_pkg;

   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_PASS = 2'd1,
      ST_FAIL = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      FC_NONE      = 2'b00,
      FC_BAD_STORE = 2'b01,
      FC_TIMEOUT   = 2'b10
   } fail_code_t;

endpackage
`default_nettype wire

// File: rtl/store_checker_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | store_checker_if : store stream in, verdict and counters out       |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
interface store_checker_if #(
   parameter int CNT_W = 16
) ();
   logic             mem_write_i;
   logic [31:0]      data_adr_i;
   logic [31:0]      write_data_i;
   logic             done_o;
   logic             pass_o;
   logic             fail_o;
   logic [1:0]       fail_code_o;
   logic [31:0]      fail_adr_o;
   logic [31:0]      fail_data_o;
   logic [CNT_W-1:0] store_count_o;
   logic [CNT_W-1:0] cycle_count_o;

   modport master (
      output mem_write_i, data_adr_i, write_data_i,
      input  done_o, pass_o, fail_o, fail_code_o, fail_adr_o, fail_data_o,
             store_count_o, cycle_count_o
   );

   modport slave (
      input  mem_write_i, data_adr_i, write_data_i,
      output done_o, pass_o, fail_o, fail_code_o, fail_adr_o, fail_data_o,
             store_count_o, cycle_count_o
   );
endinterface
`default_nettype wire

// File: rtl/store_checker_sat_counter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sat_counter : enabled up-counter that sticks at all-ones           |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en_i,
   output logic [WIDTH-1:0] q_o
);
   localparam logic [WIDTH-1:0] c_one = WIDTH'(1);

   logic [WIDTH-1:0] r_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_q <= '0;
      end else if (en_i && (r_q != '1)) begin
         r_q <= r_q + c_one;
      end
   end

   assign q_o = r_q;
endmodule
`default_nettype wire

// File: rtl/store_checker.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | store_checker : end-of-test verdict from the CPU data-store stream |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module store_checker
   import store_checker_pkg::*;
#(
   parameter logic [31:0] PASS_ADDR      = 32'd100,
   parameter logic [31:0] PASS_DATA      = 32'd25,
   parameter logic [31:0] ALLOW_ADDR     = 32'd96,
   parameter int          TIMEOUT_CYCLES = 1000,
   parameter int          CNT_W          = 16
) (
   input  logic           clk,
   input  logic           reset,
   store_checker_if.slave bus
);
   localparam logic [31:0] c_timeout_last = 32'(TIMEOUT_CYCLES - 1);

   state_t           r_state, w_state_next;
   fail_code_t       r_fail_code, w_fail_code_next;
   logic [31:0]      r_fail_adr, w_fail_adr_next;
   logic [31:0]      r_fail_data, w_fail_data_next;
   logic             w_store_inc, w_cycle_inc;
   logic             w_pass_hit, w_allow_hit, w_timeout_hit;
   logic [CNT_W-1:0] w_store_count, w_cycle_count;

   // Equality on unknown inputs evaluates non-true, so X/Z stores fall to the bad-store branch
   assign w_pass_hit    = (bus.data_adr_i == PASS_ADDR) && (bus.write_data_i == PASS_DATA);
   assign w_allow_hit   = (bus.data_adr_i == ALLOW_ADDR);
   assign w_timeout_hit = (32'(w_cycle_count) == c_timeout_last);

   always_comb begin
      w_state_next     = r_state;
      w_fail_code_next = r_fail_code;
      w_fail_adr_next  = r_fail_adr;
      w_fail_data_next = r_fail_data;
      w_store_inc      = 1'b0;
      w_cycle_inc      = 1'b0;
      if (r_state == ST_RUN) begin
         if (bus.mem_write_i) begin
            if (w_pass_hit) begin
               w_state_next = ST_PASS;
               w_store_inc  = 1'b1;
            end else if (w_allow_hit) begin
               w_store_inc  = 1'b1;
            end else begin
               w_state_next     = ST_FAIL;
               w_fail_code_next = FC_BAD_STORE;
               w_fail_adr_next  = bus.data_adr_i;
               w_fail_data_next = bus.write_data_i;
            end
         end
         // Timeout only when the store (if any) left us in RUN; the counter freezes on exit
         if (w_state_next == ST_RUN) begin
            if (w_timeout_hit) begin
               w_state_next     = ST_FAIL;
               w_fail_code_next = FC_TIMEOUT;
            end else begin
               w_cycle_inc = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= ST_RUN;
         r_fail_code <= FC_NONE;
         r_fail_adr  <= '0;
         r_fail_data <= '0;
      end else begin
         r_state     <= w_state_next;
         r_fail_code <= w_fail_code_next;
         r_fail_adr  <= w_fail_adr_next;
         r_fail_data <= w_fail_data_next;
      end
   end

   sat_counter #(.WIDTH(CNT_W)) u_store_cnt (
      .clk   (clk),
      .reset (reset),
      .en_i  (w_store_inc),
      .q_o   (w_store_count)
   );

   sat_counter #(.WIDTH(CNT_W)) u_cycle_cnt (
      .clk   (clk),
      .reset (reset),
      .en_i  (w_cycle_inc),
      .q_o   (w_cycle_count)
   );

   assign bus.pass_o        = (r_state == ST_PASS);
   assign bus.fail_o        = (r_state == ST_FAIL);
   assign bus.done_o        = (r_state == ST_PASS) || (r_state == ST_FAIL);
   assign bus.fail_code_o   = r_fail_code;
   assign bus.fail_adr_o    = r_fail_adr;
   assign bus.fail_data_o   = r_fail_data;
   assign bus.store_count_o = w_store_count;
   assign bus.cycle_count_o = w_cycle_count;
endmodule
`default_nettype wire

// File: tb/tb_store_checker.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_store_checker : vector table plus corner sequences for checker  |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module tb_store_checker;

   typedef struct {
      logic        done;
      logic        pass;
      logic        fail;
      logic [1:0]  code;
      logic [31:0] fadr;
      logic [31:0] fdata;
      int          scnt;
      int          ccnt;
   } exp_t;

   typedef struct {
      bit          rst;
      logic        we;
      logic [31:0] adr;
      logic [31:0] data;
      exp_t        e;
   } vec_t;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   n_tests = 0;
   int   n_fail = 0;
   int   vid = 0;
   exp_t sb_q[$];
   int   sb_b[$];
   vec_t tbl[$];

   always #5 clk = ~clk;

   store_checker_if #(.CNT_W(16)) a_if ();
   store_checker_if #(.CNT_W(3))  b_if ();

   store_checker #(
      .PASS_ADDR(32'd100), .PASS_DATA(32'd25), .ALLOW_ADDR(32'd96),
      .TIMEOUT_CYCLES(10), .CNT_W(16)
   ) u_dut_a (
      .clk   (clk),
      .reset (reset),
      .bus   (a_if.slave)
   );

   store_checker #(
      .PASS_ADDR(32'd100), .PASS_DATA(32'd25), .ALLOW_ADDR(32'd96),
      .TIMEOUT_CYCLES(1000), .CNT_W(3)
   ) u_dut_b (
      .clk   (clk),
      .reset (reset),
      .bus   (b_if.slave)
   );

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(bit r, logic we, logic [31:0] adr, logic [31:0] data,
                               logic p, logic f, logic [1:0] c, logic [31:0] fa,
                               logic [31:0] fd, int sc, int cc);
      vec_t v;
      v.rst = r; v.we = we; v.adr = adr; v.data = data;
      v.e.pass = p; v.e.fail = f; v.e.done = p | f; v.e.code = c;
      v.e.fadr = fa; v.e.fdata = fd; v.e.scnt = sc; v.e.ccnt = cc;
      return v;
   endfunction

   task automatic check_a(input string tag, input exp_t e);
      check({tag, ".done"},  32'(a_if.done_o),        32'(e.done));
      check({tag, ".pass"},  32'(a_if.pass_o),        32'(e.pass));
      check({tag, ".fail"},  32'(a_if.fail_o),        32'(e.fail));
      check({tag, ".code"},  32'(a_if.fail_code_o),   32'(e.code));
      check({tag, ".fadr"},  a_if.fail_adr_o,         e.fadr);
      check({tag, ".fdata"}, a_if.fail_data_o,        e.fdata);
      check({tag, ".scnt"},  32'(a_if.store_count_o), 32'(e.scnt));
      check({tag, ".ccnt"},  32'(a_if.cycle_count_o), 32'(e.ccnt));
   endtask

   // Reset asserted mid-cycle: outputs must clear before any clock edge
   task automatic do_reset();
      a_if.mem_write_i = 1'b0;
      b_if.mem_write_i = 1'b0;
      reset = 1'b0;
      #1;
      check_a("rst", mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0).e);
      check("rst.b_scnt", 32'(b_if.store_count_o), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   task automatic run_vec(input vec_t v);
      string tag;
      exp_t  e;
      if (v.rst) do_reset();
      a_if.mem_write_i  = v.we;
      a_if.data_adr_i   = v.adr;
      a_if.write_data_i = v.data;
      sb_q.push_back(v.e);
      @(posedge clk);
      #1;
      a_if.mem_write_i = 1'b0;
      tag = $sformatf("v%0d", vid);
      vid++;
      if (sb_q.size() == 0) begin
         n_tests++; n_fail++;
         $display("FAIL %s.sb: got empty scoreboard, expected an entry", tag);
      end else begin
         e = sb_q.pop_front();
         check_a(tag, e);
      end
   endtask

   initial begin
      a_if.mem_write_i = 1'b0; a_if.data_adr_i = '0; a_if.write_data_i = '0;
      b_if.mem_write_i = 1'b0; b_if.data_adr_i = '0; b_if.write_data_i = '0;

      // Pass sequence: three scratch stores, then the pass store, then ignored input
      tbl.push_back(mk(1, 1, 96,  7,   0, 0, 2'b00, 0,   0,  1, 1));
      tbl.push_back(mk(0, 1, 96,  7,   0, 0, 2'b00, 0,   0,  2, 2));
      tbl.push_back(mk(0, 1, 96,  7,   0, 0, 2'b00, 0,   0,  3, 3));
      tbl.push_back(mk(0, 1, 100, 25,  1, 0, 2'b00, 0,   0,  4, 3));
      tbl.push_back(mk(0, 1, 100, 24,  1, 0, 2'b00, 0,   0,  4, 3));
      // Wrong data at the pass address on the first edge after reset (reset taken from PASS)
      tbl.push_back(mk(1, 1, 100, 24,  0, 1, 2'b01, 100, 24, 0, 0));
      // Bad address after two legal stores; later pass stores change nothing
      tbl.push_back(mk(1, 1, 96,  1,   0, 0, 2'b00, 0,   0,  1, 1));
      tbl.push_back(mk(0, 1, 96,  2,   0, 0, 2'b00, 0,   0,  2, 2));
      tbl.push_back(mk(0, 1, 32'h40, 32'hdead, 0, 1, 2'b01, 32'h40, 32'hdead, 2, 2));
      tbl.push_back(mk(0, 1, 100, 25,  0, 1, 2'b01, 32'h40, 32'hdead, 2, 2));
      tbl.push_back(mk(0, 1, 100, 25,  0, 1, 2'b01, 32'h40, 32'hdead, 2, 2));
      // Strobe low: address/data must be ignored
      tbl.push_back(mk(1, 0, 100, 25,  0, 0, 2'b00, 0,   0,  0, 1));
      tbl.push_back(mk(0, 0, 32'h44, 1, 0, 0, 2'b00, 0,   0,  0, 2));

      foreach (tbl[i]) run_vec(tbl[i]);

      // Timeout: idle RUN edges 1..9 count up, edge 10 fails with code 10 and count frozen at 9
      for (int k = 1; k <= 9; k++)
         run_vec(mk(k == 1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, k));
      for (int k = 0; k < 3; k++)
         run_vec(mk(0, 0, 0, 0, 0, 1, 2'b10, 0, 0, 0, 9));

      // Pass store on the timeout edge wins
      for (int k = 1; k <= 9; k++)
         run_vec(mk(k == 1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, k));
      run_vec(mk(0, 1, 100, 25, 1, 0, 2'b00, 0, 0, 1, 9));

      // Bad store on the timeout edge beats the timeout
      for (int k = 1; k <= 9; k++)
         run_vec(mk(k == 1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, k));
      run_vec(mk(0, 1, 32'h50, 3, 0, 1, 2'b01, 32'h50, 3, 0, 9));

      // 3-bit counters: nine scratch stores saturate at 7, pass is still reached
      do_reset();
      for (int i = 0; i < 9; i++) begin
         b_if.mem_write_i  = 1'b1;
         b_if.data_adr_i   = 32'd96;
         b_if.write_data_i = 32'(i);
         sb_b.push_back((i + 1 > 7) ? 7 : i + 1);
         @(posedge clk);
         #1;
         check($sformatf("sat%0d.scnt", i), 32'(b_if.store_count_o), 32'(sb_b.pop_front()));
         check($sformatf("sat%0d.pass", i), 32'(b_if.pass_o), 32'd0);
      end
      b_if.data_adr_i   = 32'd100;
      b_if.write_data_i = 32'd25;
      sb_b.push_back(7);
      @(posedge clk);
      #1;
      b_if.mem_write_i = 1'b0;
      check("sat_end.scnt", 32'(b_if.store_count_o), 32'(sb_b.pop_front()));
      check("sat_end.pass", 32'(b_if.pass_o), 32'd1);
      check("sat_end.fail", 32'(b_if.fail_o), 32'd0);
      check("sat_end.ccnt", 32'(b_if.cycle_count_o), 32'd7);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/store_checker.md
# store_checker

Synthesizable end-of-test monitor that sits directly downstream of the CPU `top` data-memory write port. It consumes the per-cycle store stream (`MemWrite`, `DataAdr`, `WriteData`) and decides pass or fail. A store of the expected value to the expected address is a pass; a store to any address outside an allowed scratch address is a fail; running too long without finishing is a timeout. It replaces simulation-only checking, so the same verdict is available on FPGA LEDs and in the testbench.

## Interface
Parameters:
- `PASS_ADDR`, default 100: address whose store ends the test.
- `PASS_DATA`, default 25: data required at `PASS_ADDR` for a pass.
- `ALLOW_ADDR`, default 96: scratch address; stores to it are legal and counted.
- `TIMEOUT_CYCLES`, default 1000: cycles in RUN before a timeout fail; must be ≥ 2.
- `CNT_W`, default 16: width of the store and cycle counters.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `mem_write_i` in 1: store strobe from `top` (`MemWrite`).
- `data_adr_i` in 32: store address (`DataAdr`).
- `write_data_i` in 32: store data (`WriteData`).
- `done_o` out 1: verdict reached. Sticky.
- `pass_o` out 1: test passed. Sticky.
- `fail_o` out 1: test failed. Sticky.
- `fail_code_o` out 2: `00` none, `01` bad store, `10` timeout.
- `fail_adr_o` out 32: address of the offending store; 0 on timeout.
- `fail_data_o` out 32: data of the offending store; 0 on timeout.
- `store_count_o` out CNT_W: legal stores accepted so far, saturating.
- `cycle_count_o` out CNT_W: cycles spent in RUN, saturating.

## Operation
- States: RUN, PASS, FAIL.
- Reset asserted: state RUN; all outputs and counters at 0.
- RUN, each rising edge, with `mem_write_i` = 1:
  - `data_adr_i` == `PASS_ADDR` and `write_data_i` == `PASS_DATA`: go to PASS; increment `store_count_o`.
  - `data_adr_i` == `ALLOW_ADDR` (any data): stay in RUN; increment `store_count_o`.
  - Any other address, including `PASS_ADDR` with wrong data: go to FAIL with code `01`; capture address and data into `fail_adr_o`/`fail_data_o`; `store_count_o` is not incremented.
- RUN, with `mem_write_i` = 0: no store action.
- Cycle counter:
  - `cycle_count_o` increments every RUN cycle.
  - When it equals `TIMEOUT_CYCLES-1` and no pass or fail store occurs that edge: go to FAIL with code `10`.
- Priority within one edge: pass store > bad store > timeout.
- If `PASS_ADDR` == `ALLOW_ADDR`, the pass rule wins; a wrong-data store to that address is then legal.
- PASS/FAIL are terminal:
  - Inputs are ignored.
  - Both counters and all captured fields freeze.
  - Only reset leaves them.
- Counters saturate at all-ones and never wrap.
- Inputs that are X/Z while `mem_write_i` = 1 are treated as a mismatch, so X propagation surfaces as a fail in simulation.

## Timing
- Verdict latency: 1 cycle. Outputs reflect a store on the edge that samples it and are visible from then on.
- `done_o` = `pass_o` | `fail_o`. `pass_o` and `fail_o` are never both 1.
- Reset mid-test: outputs clear immediately (asynchronous assert). Checking restarts on the first edge after reset deasserts.
- The store sampled on the first edge after deassertion is checked normally.
- `top` resets with an active-high `reset`; the integrator inverts it at the instance.

## Structure
- Package `store_checker_pkg`:
  - state enum: `ST_RUN`, `ST_PASS`, `ST_FAIL`.
  - fail-code enum: `FC_NONE`, `FC_BAD_STORE`, `FC_TIMEOUT`.
- One sub-module, `sat_counter`:
  - parameter: width.
  - ports: `clk`, `reset` (active-low asynchronous), `en_i`, `q_o`.
  - instantiated twice, for the store count and the cycle count.
- Everything else is a single FSM plus capture registers in `store_checker`.

## Test plan
- Program stores 7 to address 96 three times, then 25 to address 100 → `store_count_o`=4, `pass_o`=1 one edge after the final store, `fail_code_o`=`00`.
- Store 24 to address 100 → `fail_o`=1, `fail_code_o`=`01`, `fail_adr_o`=100, `fail_data_o`=24, `store_count_o`=0.
- Store to address 0x40 after two legal stores → FAIL code `01`, `fail_adr_o`=0x40. Later stores to address 100 leave the outputs unchanged.
- No stores, `TIMEOUT_CYCLES`=10 → `fail_code_o`=`10` after the 10th RUN edge, `cycle_count_o`=9 frozen. A pass store on that same edge instead gives PASS.
- Assert reset for 3 cycles while in PASS → all outputs 0 immediately. After release, a fresh pass sequence passes again.
- `CNT_W`=3 with 9 legal stores then a pass store → `store_count_o` saturates at 7, and PASS is still reached.
